sig_debounce: RTL and testbench

//   Conditions a raw asynchronous level (key, external strobe) before the posedge/falledge/anyedge

---
 rtl/sig_debounce_pkg.sv | 11 +
 rtl/sig_sync.sv | 29 ++
 rtl/sig_debounce.sv | 120 ++++++++++++
 tb/tb_sig_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_debounce_pkg.sv
// rtl/sig_debounce_pkg.sv - shared FSM state encoding for the debouncer
// Purpose : state type shared by sig_debounce and its bench-visible internals.
// Ports   : none (package).
package sig_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } db_state_t;

endpackage

// File: rtl/sig_sync.sv
// rtl/sig_sync.sv - multi-flop level synchroniser for asynchronous inputs
// Purpose : brings an asynchronous level into the clk domain through a flop chain.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset, loads RST_VAL into every stage
//           d     - asynchronous input level
//           q     - synchronised level (last stage)
module sig_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// rtl/sig_debounce.sv - synchronise and debounce a raw level, emit clean edge pulses
// Purpose : resynchronises sig_in, then accepts a new level only after it has been
//           seen on DEBOUNCE_CYCLES consecutive sampling edges.
// Ports   : clk         - system clock
//           rst_n       - asynchronous active-low reset
//           sig_in      - raw asynchronous level
//           sig_db      - debounced level (registered)
//           sig_db_rise - one-cycle pulse on the edge sig_db goes 0->1
//           sig_db_fall - one-cycle pulse on the edge sig_db goes 1->0
//           busy        - high while a candidate change is being qualified
//           glitch      - one-cycle pulse when a candidate change is rejected
module sig_debounce
    import sig_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_db,
    output logic sig_db_rise,
    output logic sig_db_fall,
    output logic busy,
    output logic glitch
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             w_db_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_glitch;
    logic             w_glitch_nxt;
    logic             r_busy;

    sig_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .q     (w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_db     <= RST_VAL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_db     <= w_db_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_glitch <= w_glitch_nxt;
            r_busy   <= (w_state_nxt == ST_CHECK);
        end
    end

    // r_cnt holds how many consecutive edges the new level has already been seen,
    // so the edge that finds r_cnt == DEBOUNCE_CYCLES-1 is the last qualifying one.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = '0;
        w_db_nxt     = r_db;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_glitch_nxt = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_s != r_db) begin
                    w_state_nxt = ST_CHECK;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (w_s == r_db) begin
                    // Any reversion throws away all accumulated credit.
                    w_state_nxt  = ST_STABLE;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_STABLE;
                    w_db_nxt    = w_s;
                    w_rise_nxt  = w_s;
                    w_fall_nxt  = ~w_s;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign sig_db      = r_db;
    assign sig_db_rise = r_rise;
    assign sig_db_fall = r_fall;
    assign busy        = r_busy;
    assign glitch      = r_glitch;

endmodule

// File: tb/tb_sig_debounce.sv
// tb/tb_sig_debounce.sv - self-checking bench for sig_debounce
module tb_sig_debounce;

    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sig_in;
    logic sig_db, sig_db_rise, sig_db_fall, busy, glitch;
    logic rst_n2, sig_in2;
    logic sig_db2, sig_db_rise2, sig_db_fall2, busy2, glitch2;

    sig_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .RST_VAL(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .sig_db      (sig_db),
        .sig_db_rise (sig_db_rise),
        .sig_db_fall (sig_db_fall),
        .busy        (busy),
        .glitch      (glitch)
    );

    sig_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .RST_VAL(1'b1)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n2),
        .sig_in      (sig_in2),
        .sig_db      (sig_db2),
        .sig_db_rise (sig_db_rise2),
        .sig_db_fall (sig_db_fall2),
        .busy        (busy2),
        .glitch      (glitch2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] outs1();
        return {sig_db, sig_db_rise, sig_db_fall, busy, glitch};
    endfunction

    function automatic logic [4:0] outs2();
        return {sig_db2, sig_db_rise2, sig_db_fall2, busy2, glitch2};
    endfunction

    // Counter bound monitors.
    logic cnt_viol1 = 1'b0;
    logic cnt_viol2 = 1'b0;
    always @(negedge clk) begin
        if (int'(dut.r_cnt) > DC - 1) cnt_viol1 <= 1'b1;
        if (int'(dut2.r_cnt) > 1)     cnt_viol2 <= 1'b1;
    end

    // Reference model: s lags sig_in by SYNC edges; the level flips once s has
    // disagreed with it for DC consecutive edges.
    logic m_q[$];
    logic m_db;
    int   m_run;
    logic [4:0] m_out;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        m_db  = 1'b0;
        m_run = 0;
        m_out = '0;
    endtask

    task automatic model_edge(input logic din);
        logic s, r, f, g;
        s = m_q[SYNC-1];
        r = 1'b0; f = 1'b0; g = 1'b0;
        if (s != m_db) begin
            m_run++;
            if (m_run == DC) begin
                r = s; f = ~s; m_db = s; m_run = 0;
            end
        end else begin
            g = (m_run > 0);
            m_run = 0;
        end
        m_q.push_front(din);
        void'(m_q.pop_back());
        m_out = {m_db, r, f, (m_run > 0), g};
    endtask

    typedef struct {
        logic       in;
        logic [4:0] exp;   // {db, rise, fall, busy, glitch} after the edge
    } vec_t;

    vec_t tbl[24];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hold;
        logic cur;
        bit seen;

        // clean step
        tbl[0]  = '{1'b1, 5'b00000};
        tbl[1]  = '{1'b1, 5'b00000};
        tbl[2]  = '{1'b1, 5'b00010};
        tbl[3]  = '{1'b1, 5'b00010};
        tbl[4]  = '{1'b1, 5'b00010};
        tbl[5]  = '{1'b1, 5'b11000};
        tbl[6]  = '{1'b1, 5'b10000};
        // release
        tbl[7]  = '{1'b0, 5'b10000};
        tbl[8]  = '{1'b0, 5'b10000};
        tbl[9]  = '{1'b0, 5'b10010};
        tbl[10] = '{1'b0, 5'b10010};
        tbl[11] = '{1'b0, 5'b10010};
        tbl[12] = '{1'b0, 5'b00100};
        tbl[13] = '{1'b0, 5'b00000};
        // bounce: high 2, low 1, then held high
        tbl[14] = '{1'b1, 5'b00000};
        tbl[15] = '{1'b1, 5'b00000};
        tbl[16] = '{1'b0, 5'b00010};
        tbl[17] = '{1'b1, 5'b00010};
        tbl[18] = '{1'b1, 5'b00001};
        tbl[19] = '{1'b1, 5'b00010};
        tbl[20] = '{1'b1, 5'b00010};
        tbl[21] = '{1'b1, 5'b00010};
        tbl[22] = '{1'b1, 5'b11000};
        tbl[23] = '{1'b1, 5'b10000};

        rst_n = 1'b0; sig_in = 1'b0;
        rst_n2 = 1'b0; sig_in2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs1()), 32'h0);
        chk("reset_outs_rv1", 32'(outs2()), 32'h10);

        // idle low
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_%0d", i), 32'(outs1()), 32'h0);
        end

        for (int i = 0; i < 24; i++) begin
            sig_in = tbl[i].in;
            @(negedge clk);
            chk($sformatf("vec_%0d", i), 32'(outs1()), 32'(tbl[i].exp));
        end

        // reset mid-CHECK
        sig_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("midcheck_busy_seen", 32'(seen), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("midcheck_reset_outs", 32'(outs1()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort_%0d", i), 32'(outs1()), 32'h0);
        end

        // DEBOUNCE_CYCLES=2, RST_VAL=1, input low at release
        rst_n2 = 1'b1;
        begin
            logic [4:0] e2 [6];
            e2[0] = 5'b10000; e2[1] = 5'b10000; e2[2] = 5'b10010;
            e2[3] = 5'b00100; e2[4] = 5'b00000; e2[5] = 5'b00000;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk($sformatf("rv1_edge_%0d", i), 32'(outs2()), 32'(e2[i]));
            end
        end

        // randomized runs against the model
        rst_n = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cur = 1'b0;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                cur  = ~cur;
                hold = $urandom_range(1, 7);
            end
            hold--;
            sig_in = cur;
            @(posedge clk);
            model_edge(sig_in);
            @(negedge clk);
            chk($sformatf("rand_%0d", i), 32'(outs1()), 32'(m_out));
        end

        chk("cnt_bound_dc4", 32'(cnt_viol1), 32'h0);
        chk("cnt_bound_dc2", 32'(cnt_viol2), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
